// File: rtl/lock_code_writer.sv
// Password-programming front end for the switch/button lock: prove the current
// code, enter and confirm a new one, then commit it to passw.
module lock_code_writer #(
    parameter logic [3:0] DEFAULT_CODE   = 4'b1001,
    parameter int         MAX_TRIES      = 3,
    parameter int         TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       prog_i,
    input  logic       enter_i,
    input  logic       oops_i,
    input  logic [3:0] login_i,
    output logic [3:0] passw_o,
    output logic [3:0] led_o,
    output logic       busy_o
);

    localparam int            TW           = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        VERIFY,
        NEW1,
        NEW2,
        DONE,
        FAIL
    } state_t;

    // Button vectors are ordered {prog, enter, oops}.
    logic [2:0]    btnMeta_q, btnSync_q, btnPrev_q, btnPulse_q;
    logic [3:0]    loginMeta_q, loginSync_q;

    state_t        state_q, state_d;
    logic [1:0]    tries_q, tries_d;
    logic [1:0]    triesInc;
    logic [3:0]    candidate_q, candidate_d;
    logic [3:0]    passw_q, passw_d;
    logic [3:0]    led_q, led_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          progPulse, enterPulse, oopsPulse;
    logic          enterAccepted;
    logic          timeout;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            btnMeta_q   <= '0;
            btnSync_q   <= '0;
            btnPrev_q   <= '0;
            btnPulse_q  <= '0;
            loginMeta_q <= '0;
            loginSync_q <= '0;
        end else begin
            btnMeta_q   <= {prog_i, enter_i, oops_i};
            btnSync_q   <= btnMeta_q;
            btnPrev_q   <= btnSync_q;
            btnPulse_q  <= btnSync_q & ~btnPrev_q;
            loginMeta_q <= login_i;
            loginSync_q <= loginMeta_q;
        end
    end

    assign progPulse  = btnPulse_q[2];
    assign enterPulse = btnPulse_q[1];
    assign oopsPulse  = btnPulse_q[0];

    assign timeout  = (state_q != IDLE) && (timer_q == TIMEOUT_LAST);
    assign triesInc = (tries_q == 2'b11) ? tries_q : tries_q + 2'd1;

    // Timeout beats any pulse; oops beats enter in the states it can cancel.
    always_comb begin
        state_d       = state_q;
        tries_d       = tries_q;
        candidate_d   = candidate_q;
        passw_d       = passw_q;
        enterAccepted = 1'b0;

        if (timeout) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (progPulse) begin
                        state_d = VERIFY;
                        tries_d = 2'd0;
                    end
                end
                VERIFY: begin
                    if (oopsPulse) begin
                        state_d = IDLE;
                    end else if (enterPulse) begin
                        enterAccepted = 1'b1;
                        if (loginSync_q == passw_q) begin
                            state_d = NEW1;
                        end else begin
                            tries_d = triesInc;
                            if (int'(triesInc) >= MAX_TRIES) begin
                                state_d = FAIL;
                            end
                        end
                    end
                end
                NEW1: begin
                    if (oopsPulse) begin
                        state_d = IDLE;
                    end else if (enterPulse) begin
                        enterAccepted = 1'b1;
                        candidate_d   = loginSync_q;
                        state_d       = NEW2;
                    end
                end
                NEW2: begin
                    if (oopsPulse) begin
                        state_d = IDLE;
                    end else if (enterPulse) begin
                        enterAccepted = 1'b1;
                        if (loginSync_q == candidate_q) begin
                            passw_d = candidate_q;
                            state_d = DONE;
                        end else begin
                            candidate_d = 4'd0;
                            state_d     = NEW1;
                        end
                    end
                end
                DONE: begin
                    if (oopsPulse) begin
                        state_d = IDLE;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Inactivity timer only runs while a session is open.
    always_comb begin
        timer_d = timer_q + TW'(1);
        if ((state_q == IDLE) || (state_d != state_q) || enterAccepted) begin
            timer_d = '0;
        end
    end

    always_comb begin
        led_d = 4'b0000;
        case (state_d)
            IDLE:    led_d = 4'b0000;
            VERIFY:  led_d = 4'b0001;
            NEW1:    led_d = 4'b0010;
            NEW2:    led_d = 4'b0100;
            DONE:    led_d = 4'b0110;
            FAIL:    led_d = 4'b1100;
            default: led_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            tries_q     <= 2'd0;
            candidate_q <= 4'd0;
            passw_q     <= DEFAULT_CODE;
            led_q       <= 4'b0000;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            tries_q     <= tries_d;
            candidate_q <= candidate_d;
            passw_q     <= passw_d;
            led_q       <= led_d;
            timer_q     <= timer_d;
        end
    end

    assign passw_o = passw_q;
    assign led_o   = led_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_lock_code_writer.sv
// Scoreboard bench for lock_code_writer: stimulus queues the expected
// {led, passw, busy} for each output change and a monitor checks them in order.
module tb_lock_code_writer;

    localparam logic [2:0] PROG  = 3'b100;
    localparam logic [2:0] ENTER = 3'b010;
    localparam logic [2:0] OOPS  = 3'b001;

    logic       clk;
    logic       reset;
    logic       prog;
    logic       enter;
    logic       oops;
    logic [3:0] login;
    logic [3:0] passw;
    logic [3:0] led;
    logic       busy;

    logic [8:0] expQ[$];
    int         total;
    int         bad;
    logic       monitorOn;

    lock_code_writer #(
        .DEFAULT_CODE  (4'b1001),
        .MAX_TRIES     (3),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .prog_i (prog),
        .enter_i(enter),
        .oops_i (oops),
        .login_i(login),
        .passw_o(passw),
        .led_o  (led),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got {led,passw,busy}=%b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input logic [3:0] expLed, input logic [3:0] expPassw, input logic expBusy);
        expQ.push_back({expLed, expPassw, expBusy});
    endtask

    // Sets the switches one cycle ahead, then holds the buttons in mask.
    task automatic applyStimulus(input logic [2:0] mask, input logic [3:0] code, input int holdCycles);
        @(posedge clk);
        #1 login = code;
        @(posedge clk);
        #1 {prog, enter, oops} = mask;
        repeat (holdCycles) @(posedge clk);
        #1 {prog, enter, oops} = 3'b000;
        repeat (3) @(posedge clk);
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (expQ.size() == 0) break;
            @(posedge clk);
        end
        checkOutput(name, 9'(expQ.size()), 9'd0);
    endtask

    initial begin : monitor
        logic [8:0] prev;
        logic [8:0] cur;
        logic [8:0] exp;
        wait (monitorOn);
        prev = {led, passw, busy};
        forever begin
            @(negedge clk);
            cur = {led, passw, busy};
            if (cur !== prev) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_change", cur, prev);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("transition", cur, exp);
                end
                prev = cur;
            end
        end
    end

    initial begin : stimulus
        total     = 0;
        bad       = 0;
        monitorOn = 1'b0;
        reset     = 1'b1;
        {prog, enter, oops} = 3'b000;
        login     = 4'b0000;
        repeat (3) @(posedge clk);
        #1 checkOutput("reset_state", {led, passw, busy}, {4'b0000, 4'b1001, 1'b0});
        @(posedge clk);
        #1 reset = 1'b0;
        monitorOn = 1'b1;
        repeat (2) @(posedge clk);

        // enter and oops while idle must not move anything
        applyStimulus(ENTER, 4'b1001, 5);
        applyStimulus(OOPS, 4'b1001, 5);

        // happy path: 1001 -> 0110
        pushExp(4'b0001, 4'b1001, 1'b1); applyStimulus(PROG,  4'b1001, 5);
        pushExp(4'b0010, 4'b1001, 1'b1); applyStimulus(ENTER, 4'b1001, 5);
        pushExp(4'b0100, 4'b1001, 1'b1); applyStimulus(ENTER, 4'b0110, 5);
        pushExp(4'b0110, 4'b0110, 1'b1); applyStimulus(ENTER, 4'b0110, 5);
        pushExp(4'b0000, 4'b0110, 1'b0); applyStimulus(OOPS,  4'b0110, 5);
        waitDrain("drain_happy");

        // confirm mismatch returns to NEW1, then commit 0111
        pushExp(4'b0001, 4'b0110, 1'b1); applyStimulus(PROG,  4'b0110, 5);
        pushExp(4'b0010, 4'b0110, 1'b1); applyStimulus(ENTER, 4'b0110, 5);
        pushExp(4'b0100, 4'b0110, 1'b1); applyStimulus(ENTER, 4'b0101, 5);
        pushExp(4'b0010, 4'b0110, 1'b1); applyStimulus(ENTER, 4'b0111, 5);
        pushExp(4'b0100, 4'b0110, 1'b1); applyStimulus(ENTER, 4'b0111, 5);
        pushExp(4'b0110, 4'b0111, 1'b1); applyStimulus(ENTER, 4'b0111, 5);
        pushExp(4'b0000, 4'b0111, 1'b0); applyStimulus(OOPS,  4'b0111, 5);
        waitDrain("drain_mismatch");

        // lockout after three wrong codes; oops/prog ignored; timeout exit
        pushExp(4'b0001, 4'b0111, 1'b1); applyStimulus(PROG,  4'b0000, 5);
        applyStimulus(ENTER, 4'b0000, 5);
        applyStimulus(ENTER, 4'b0000, 5);
        pushExp(4'b1100, 4'b0111, 1'b1); applyStimulus(ENTER, 4'b0000, 5);
        applyStimulus(OOPS | PROG | ENTER, 4'b0111, 5);
        checkOutput("fail_hold", {led, passw, busy}, {4'b1100, 4'b0111, 1'b1});
        pushExp(4'b0000, 4'b0111, 1'b0);
        waitDrain("drain_lockout");

        // tries restart at zero: two wrong entries then the right one
        pushExp(4'b0001, 4'b0111, 1'b1); applyStimulus(PROG,  4'b0000, 5);
        applyStimulus(ENTER, 4'b0000, 5);
        applyStimulus(ENTER, 4'b0000, 5);
        pushExp(4'b0010, 4'b0111, 1'b1); applyStimulus(ENTER, 4'b0111, 5);
        pushExp(4'b0100, 4'b0111, 1'b1); applyStimulus(ENTER, 4'b0101, 5);
        pushExp(4'b0000, 4'b0111, 1'b0); applyStimulus(OOPS,  4'b0101, 5);
        waitDrain("drain_cancel");

        // oops together with a correct enter in VERIFY cancels
        pushExp(4'b0001, 4'b0111, 1'b1); applyStimulus(PROG,  4'b0111, 5);
        pushExp(4'b0000, 4'b0111, 1'b0); applyStimulus(OOPS | ENTER, 4'b0111, 5);
        waitDrain("drain_oops_enter");

        // held enter gives one step to NEW2, then the session times out
        pushExp(4'b0001, 4'b0111, 1'b1); applyStimulus(PROG,  4'b0111, 5);
        pushExp(4'b0010, 4'b0111, 1'b1); applyStimulus(ENTER, 4'b0111, 5);
        pushExp(4'b0100, 4'b0111, 1'b1);
        pushExp(4'b0000, 4'b0111, 1'b0); applyStimulus(ENTER, 4'b1010, 50);
        waitDrain("drain_held");

        // commit 0110, then async reset in the middle of NEW2
        pushExp(4'b0001, 4'b0111, 1'b1); applyStimulus(PROG,  4'b0111, 5);
        pushExp(4'b0010, 4'b0111, 1'b1); applyStimulus(ENTER, 4'b0111, 5);
        pushExp(4'b0100, 4'b0111, 1'b1); applyStimulus(ENTER, 4'b0110, 5);
        pushExp(4'b0110, 4'b0110, 1'b1); applyStimulus(ENTER, 4'b0110, 5);
        pushExp(4'b0000, 4'b0110, 1'b0); applyStimulus(OOPS,  4'b0110, 5);
        pushExp(4'b0001, 4'b0110, 1'b1); applyStimulus(PROG,  4'b0110, 5);
        pushExp(4'b0010, 4'b0110, 1'b1); applyStimulus(ENTER, 4'b0110, 5);
        pushExp(4'b0100, 4'b0110, 1'b1); applyStimulus(ENTER, 4'b0011, 5);
        waitDrain("drain_before_reset");
        @(posedge clk);
        #2;
        pushExp(4'b0000, 4'b1001, 1'b0);
        reset = 1'b1;
        #1 checkOutput("async_reset", {led, passw, busy}, {4'b0000, 4'b1001, 1'b0});
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        waitDrain("drain_reset");

        repeat (5) @(posedge clk);
        checkOutput("queue_empty", 9'(expQ.size()), 9'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
